// File: rtl/lsu_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_cache_arbiter
// Purpose  : Shares the single data-cache controller port between the load
//            and store units and routes each completion back to its owner.
// Revision : 1.0  initial release
// ============================================================================
module lsu_cache_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,

    input  logic            ldu_read_i,
    input  logic [XLEN-1:0] ldu_address_i,
    input  logic            ldu_cachable_i,
    output logic            ldu_data_valid_o,
    output logic [XLEN-1:0] ldu_data_o,

    input  logic            stu_write_i,
    input  logic [XLEN-1:0] stu_address_i,
    input  logic [XLEN-1:0] stu_data_i,
    input  logic [3:0]      stu_byte_en_i,
    input  logic            stu_cachable_i,
    output logic            stu_done_o,

    input  logic            cache_ctrl_idle_i,
    output logic            cache_ctrl_read_o,
    output logic            cache_ctrl_write_o,
    output logic [XLEN-1:0] cache_ctrl_address_o,
    output logic [XLEN-1:0] cache_ctrl_data_o,
    output logic [3:0]      cache_ctrl_byte_en_o,
    output logic            cache_ctrl_cachable_o,
    input  logic            cache_ctrl_data_valid_i,
    input  logic [XLEN-1:0] cache_ctrl_data_i,
    input  logic            cache_ctrl_write_done_i,

    output logic            idle_o
);

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [XLEN-1:0]   addr_q,     addr_d;
    logic [XLEN-1:0]   data_q,     data_d;
    logic [3:0]        byte_en_q,  byte_en_d;
    logic              cachable_q, cachable_d;
    logic [CNT_W-1:0]  starve_q,   starve_d;

    logic              w_same_word;
    logic              w_pick_store;
    logic              w_grant;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            byte_en_q  <= '0;
            cachable_q <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            byte_en_q  <= byte_en_d;
            cachable_q <= cachable_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        // A load to the same word as a waiting store must observe the store first.
        w_same_word  = (ldu_address_i[XLEN-1:2] == stu_address_i[XLEN-1:2]);
        w_pick_store = stu_write_i &
                       (~ldu_read_i | w_same_word | (starve_q == STARVE_MAX));
        w_grant      = (state_q == ST_IDLE) & cache_ctrl_idle_i &
                       (ldu_read_i | stu_write_i);

        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        byte_en_d  = byte_en_q;
        cachable_d = cachable_q;
        starve_d   = starve_q;

        case (state_q)
            ST_IDLE: begin
                if (w_grant) begin
                    if (w_pick_store) begin
                        state_d    = ST_WRITE;
                        addr_d     = stu_address_i;
                        data_d     = stu_data_i;
                        byte_en_d  = stu_byte_en_i;
                        cachable_d = stu_cachable_i;
                        starve_d   = '0;
                    end else begin
                        state_d    = ST_READ;
                        addr_d     = ldu_address_i;
                        data_d     = '0;
                        byte_en_d  = '0;
                        cachable_d = ldu_cachable_i;
                        if (!stu_write_i) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_READ: begin
                if (cache_ctrl_data_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (cache_ctrl_write_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Responses are only honoured in the matching state; strays never pulse.
    assign ldu_data_valid_o      = (state_q == ST_READ) & cache_ctrl_data_valid_i;
    assign ldu_data_o            = ldu_data_valid_o ? cache_ctrl_data_i : '0;
    assign stu_done_o            = (state_q == ST_WRITE) & cache_ctrl_write_done_i;

    assign cache_ctrl_read_o     = (state_q == ST_READ);
    assign cache_ctrl_write_o    = (state_q == ST_WRITE);
    assign cache_ctrl_address_o  = addr_q;
    assign cache_ctrl_data_o     = data_q;
    assign cache_ctrl_byte_en_o  = byte_en_q;
    assign cache_ctrl_cachable_o = cachable_q;

    assign idle_o = (state_q == ST_IDLE) & ~ldu_read_i & ~stu_write_i;

endmodule
`default_nettype wire

// File: tb/tb_lsu_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_cache_arbiter
// Purpose  : Random load/store traffic against a transaction-level model of
//            the arbitration policy, plus asynchronous reset scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_cache_arbiter;

    localparam int XLEN         = 32;
    localparam int STARVE_LIMIT = 4;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            ldu_read_i;
    logic [XLEN-1:0] ldu_address_i;
    logic            ldu_cachable_i;
    logic            ldu_data_valid_o;
    logic [XLEN-1:0] ldu_data_o;
    logic            stu_write_i;
    logic [XLEN-1:0] stu_address_i;
    logic [XLEN-1:0] stu_data_i;
    logic [3:0]      stu_byte_en_i;
    logic            stu_cachable_i;
    logic            stu_done_o;
    logic            cache_ctrl_idle_i;
    logic            cache_ctrl_read_o;
    logic            cache_ctrl_write_o;
    logic [XLEN-1:0] cache_ctrl_address_o;
    logic [XLEN-1:0] cache_ctrl_data_o;
    logic [3:0]      cache_ctrl_byte_en_o;
    logic            cache_ctrl_cachable_o;
    logic            cache_ctrl_data_valid_i;
    logic [XLEN-1:0] cache_ctrl_data_i;
    logic            cache_ctrl_write_done_i;
    logic            idle_o;

    always #5 clk_i = ~clk_i;

    lsu_cache_arbiter #(
        .XLEN         (XLEN),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_i                   (clk_i),
        .rst_n_i                 (rst_n_i),
        .ldu_read_i              (ldu_read_i),
        .ldu_address_i           (ldu_address_i),
        .ldu_cachable_i          (ldu_cachable_i),
        .ldu_data_valid_o        (ldu_data_valid_o),
        .ldu_data_o              (ldu_data_o),
        .stu_write_i             (stu_write_i),
        .stu_address_i           (stu_address_i),
        .stu_data_i              (stu_data_i),
        .stu_byte_en_i           (stu_byte_en_i),
        .stu_cachable_i          (stu_cachable_i),
        .stu_done_o              (stu_done_o),
        .cache_ctrl_idle_i       (cache_ctrl_idle_i),
        .cache_ctrl_read_o       (cache_ctrl_read_o),
        .cache_ctrl_write_o      (cache_ctrl_write_o),
        .cache_ctrl_address_o    (cache_ctrl_address_o),
        .cache_ctrl_data_o       (cache_ctrl_data_o),
        .cache_ctrl_byte_en_o    (cache_ctrl_byte_en_o),
        .cache_ctrl_cachable_o   (cache_ctrl_cachable_o),
        .cache_ctrl_data_valid_i (cache_ctrl_data_valid_i),
        .cache_ctrl_data_i       (cache_ctrl_data_i),
        .cache_ctrl_write_done_i (cache_ctrl_write_done_i),
        .idle_o                  (idle_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Outstanding cache transaction as the policy predicts it.
    bit          m_busy;
    bit          m_is_rd;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_ben;
    bit          m_cach;
    int          m_wait;
    int          m_loads_while_store_waits;

    // Requester-side intent.
    bit          ld_act;
    logic [31:0] ld_addr;
    bit          ld_cach;
    bit          st_act;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_ben;
    bit          st_cach;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Small word pool so same-word hazards occur regularly.
    function automatic logic [31:0] rand_addr();
        return 32'h0000_1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
    endfunction

    task automatic new_load();
        ld_act  = 1'b1;
        ld_addr = rand_addr();
        ld_cach = 1'($urandom);
    endtask

    task automatic new_store();
        st_act  = 1'b1;
        st_addr = rand_addr();
        st_data = $urandom;
        st_ben  = 4'($urandom);
        st_cach = 1'($urandom);
    endtask

    task automatic clear_model();
        m_busy = 1'b0;
        m_is_rd = 1'b0;
        m_wait = 0;
        m_loads_while_store_waits = 0;
        ld_act = 1'b0;
        st_act = 1'b0;
    endtask

    task automatic drive_quiet();
        ldu_read_i              = 1'b0;
        ldu_address_i           = '0;
        ldu_cachable_i          = 1'b0;
        stu_write_i             = 1'b0;
        stu_address_i           = '0;
        stu_data_i              = '0;
        stu_byte_en_i           = '0;
        stu_cachable_i          = 1'b0;
        cache_ctrl_idle_i       = 1'b0;
        cache_ctrl_data_valid_i = 1'b0;
        cache_ctrl_data_i       = '0;
        cache_ctrl_write_done_i = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rd",    32'(cache_ctrl_read_o),     0);
        check_eq("rst_wr",    32'(cache_ctrl_write_o),    0);
        check_eq("rst_addr",  cache_ctrl_address_o,       0);
        check_eq("rst_data",  cache_ctrl_data_o,          0);
        check_eq("rst_ben",   32'(cache_ctrl_byte_en_o),  0);
        check_eq("rst_cach",  32'(cache_ctrl_cachable_o), 0);
        check_eq("rst_ldv",   32'(ldu_data_valid_o),      0);
        check_eq("rst_ldd",   ldu_data_o,                 0);
        check_eq("rst_stdn",  32'(stu_done_o),            0);
        check_eq("rst_idle",  32'(idle_o),                1);
    endtask

    // Called just after a sampling point, i.e. between clock edges.
    task automatic reset_now();
        #1;
        drive_quiet();
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
    endtask

    task automatic step();
        bit          resp;
        bit          sp_dv;
        bit          sp_wd;
        bit          pick_st;
        bit          ld_done;
        bit          st_done;
        logic [31:0] rdata;

        @(posedge clk_i); #1;
        ldu_read_i     = ld_act;
        ldu_address_i  = ld_act ? ld_addr : $urandom;
        ldu_cachable_i = ld_act ? ld_cach : 1'($urandom);
        stu_write_i    = st_act;
        stu_address_i  = st_act ? st_addr : $urandom;
        stu_data_i     = st_act ? st_data : $urandom;
        stu_byte_en_i  = st_act ? st_ben  : 4'($urandom);
        stu_cachable_i = st_act ? st_cach : 1'($urandom);

        cache_ctrl_idle_i = ($urandom_range(0, 3) != 0);
        resp  = m_busy && (m_wait == 0);
        sp_dv = ($urandom_range(0, 7) == 0);
        sp_wd = ($urandom_range(0, 7) == 0);
        rdata = $urandom;
        cache_ctrl_data_i       = rdata;
        cache_ctrl_data_valid_i = (resp && m_is_rd)  || (sp_dv && !(m_busy && m_is_rd));
        cache_ctrl_write_done_i = (resp && !m_is_rd) || (sp_wd && !(m_busy && !m_is_rd));

        #4;
        check_eq("rd_strobe", 32'(cache_ctrl_read_o),  32'(m_busy && m_is_rd));
        check_eq("wr_strobe", 32'(cache_ctrl_write_o), 32'(m_busy && !m_is_rd));
        if (m_busy) begin
            check_eq("req_addr", cache_ctrl_address_o,        m_addr);
            check_eq("req_data", cache_ctrl_data_o,           m_data);
            check_eq("req_ben",  32'(cache_ctrl_byte_en_o),   32'(m_ben));
            check_eq("req_cach", 32'(cache_ctrl_cachable_o),  32'(m_cach));
        end
        check_eq("ld_valid", 32'(ldu_data_valid_o), 32'(resp && m_is_rd));
        check_eq("ld_data",  ldu_data_o,            (resp && m_is_rd) ? rdata : 32'h0);
        check_eq("st_done",  32'(stu_done_o),       32'(resp && !m_is_rd));
        check_eq("idle",     32'(idle_o),           32'(!m_busy && !ld_act && !st_act));

        ld_done = 1'b0;
        st_done = 1'b0;
        if (m_busy) begin
            if (resp) begin
                m_busy = 1'b0;
                if (m_is_rd) ld_done = 1'b1;
                else         st_done = 1'b1;
            end else begin
                m_wait--;
            end
        end else if (cache_ctrl_idle_i && (ld_act || st_act)) begin
            pick_st = st_act && (!ld_act || (ld_addr[31:2] == st_addr[31:2]) ||
                                 (m_loads_while_store_waits == STARVE_LIMIT));
            m_busy = 1'b1;
            m_wait = $urandom_range(0, 3);
            if (pick_st) begin
                m_is_rd = 1'b0;
                m_addr  = st_addr;
                m_data  = st_data;
                m_ben   = st_ben;
                m_cach  = st_cach;
                m_loads_while_store_waits = 0;
            end else begin
                m_is_rd = 1'b1;
                m_addr  = ld_addr;
                m_data  = 32'h0;
                m_ben   = 4'h0;
                m_cach  = ld_cach;
                if (st_act && m_loads_while_store_waits < STARVE_LIMIT)
                    m_loads_while_store_waits++;
                else if (!st_act)
                    m_loads_while_store_waits = 0;
            end
        end

        // A load unit that keeps its request high right after completion
        // issues a fresh request; that is how a store gets starved.
        if (ld_done) begin
            ld_act = 1'b0;
            if ($urandom_range(0, 3) != 0) new_load();
        end else if (!ld_act && $urandom_range(0, 2) == 0) begin
            new_load();
        end
        if (st_done) begin
            st_act = 1'b0;
            if ($urandom_range(0, 3) == 0) new_store();
        end else if (!st_act && $urandom_range(0, 3) == 0) begin
            new_store();
        end
    endtask

    initial begin
        bit reached;

        clear_model();
        drive_quiet();
        rst_n_i = 1'b0;
        #2;
        check_reset_outputs();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // Bring a load into the READ state, then reset underneath it.
        ld_act  = 1'b1;
        ld_addr = 32'h0000_1000;
        ld_cach = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            step();
            if (m_busy && m_is_rd) begin
                m_wait  = 3;
                reached = 1'b1;
            end
        end
        check_eq("reach_read", 32'(reached), 1);
        if (reached) begin
            step();
            reset_now();
        end

        for (int i = 0; i < 3000; i++) step();
        reset_now();
        for (int i = 0; i < 3000; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
